// File: rtl/ram_256x8_if.sv
// CPU-side bus bundle for the model computer's main memory: address, write data,
// read/write strobes and registered read data.
interface ram_256x8_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] out;

  modport master (
    output read, write, address, data,
    input  out
  );

  modport slave (
    input  read, write, address, data,
    output out
  );
endinterface

// File: rtl/ram_256x8.sv
// Single-port synchronous RAM with registered read data and a 1-cycle full clear on reset.
// Optional macro RAM_BYPASS_EN selects write-first on same-address read+write (default read-first).
module ram_256x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  ram_256x8_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '{default: '0};
      bus.out <= '0;
    end else begin
      if (bus.write)
        mem[bus.address] <= bus.data;
      if (bus.read) begin
`ifdef RAM_BYPASS_EN
        // The single address bus means a read+write always targets the same word.
        if (bus.write)
          bus.out <= bus.data;
        else
          bus.out <= mem[bus.address];
`else
        bus.out <= mem[bus.address];
`endif
      end
    end
  end

  strobes_known: assert property (@(posedge clk) !rst |-> !$isunknown({bus.read, bus.write}))
    else $error("ram_256x8: X/Z on read/write strobe");

endmodule

// File: tb/tb_ram_256x8.sv
// Directed self-checking bench for ram_256x8: reset clear, write/read latency, hold,
// same-cycle read+write (build-dependent), and reset overriding a concurrent write.
module tb_ram_256x8;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  ram_256x8_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_256x8 #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef RAM_BYPASS_EN
  localparam logic [7:0] SAME_ADDR_EXP = 8'h77;
`else
  localparam logic [7:0] SAME_ADDR_EXP = 8'h33;
`endif

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and return 1 time unit after the rising edge.
  task automatic op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.read    = r;
    bus.write   = w;
    bus.address = a;
    bus.data    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.address = '0;
    bus.data    = '0;
    @(posedge clk);
    #1;
    check("reset_out", bus.out, 8'h00);
    rst = 1'b0;

    // 1: load non-zero words, reset, confirm cleared
    op(0, 1, 8'h00, 8'h11);
    op(0, 1, 8'h01, 8'h22);
    op(0, 1, 8'hFF, 8'h33);
    op(1, 0, 8'hFF, 8'h00);
    check("preload_ff", bus.out, 8'h33);
    rst = 1'b1;
    op(1, 1, 8'h00, 8'h5A);
    check("rst_clears_out", bus.out, 8'h00);
    rst = 1'b0;
    op(1, 0, 8'h00, 8'h00);
    check("rst_word_00", bus.out, 8'h00);
    op(1, 0, 8'h01, 8'h00);
    check("rst_word_01", bus.out, 8'h00);
    op(1, 0, 8'hFF, 8'h00);
    check("rst_word_ff", bus.out, 8'h00);

    // 2: held write, then read
    op(0, 1, 8'h01, 8'hAA);
    op(0, 1, 8'h01, 8'hAA);
    op(0, 1, 8'h01, 8'hAA);
    check("write_no_out_change", bus.out, 8'h00);
    op(1, 0, 8'h01, 8'h00);
    check("held_write_read", bus.out, 8'hAA);

    // 3: never-written location reads zero
    op(0, 1, 8'h0A, 8'hCC);
    op(1, 0, 8'h1F, 8'h00);
    check("unwritten_1f", bus.out, 8'h00);
    op(1, 0, 8'h0A, 8'h00);
    check("read_0a", bus.out, 8'hCC);

    // 4: hold with read low, write alone leaves out alone
    op(1, 0, 8'h01, 8'h00);
    check("read_01", bus.out, 8'hAA);
    op(0, 0, 8'h02, 8'h00);
    check("hold_idle", bus.out, 8'hAA);
    op(0, 1, 8'h01, 8'h55);
    check("hold_after_write", bus.out, 8'hAA);
    op(1, 0, 8'h01, 8'h00);
    check("read_new_01", bus.out, 8'h55);

    // 5: same-cycle read and write
    op(0, 1, 8'h10, 8'h33);
    op(1, 1, 8'h10, 8'h77);
    check("rw_same_addr", bus.out, SAME_ADDR_EXP);
    op(1, 0, 8'h10, 8'h00);
    check("rw_mem_updated", bus.out, 8'h77);

    // back-to-back writes then reads with read held high
    op(0, 1, 8'h40, 8'hA1);
    op(0, 1, 8'h41, 8'hB2);
    op(0, 1, 8'h42, 8'hC3);
    op(1, 0, 8'h40, 8'h00);
    check("b2b_40", bus.out, 8'hA1);
    op(1, 0, 8'h41, 8'h00);
    check("b2b_41", bus.out, 8'hB2);
    op(1, 0, 8'h42, 8'h00);
    check("b2b_42", bus.out, 8'hC3);

    // 6: reset beats a concurrent write
    rst = 1'b1;
    op(0, 1, 8'h20, 8'h99);
    check("rst_write_out", bus.out, 8'h00);
    rst = 1'b0;
    op(1, 0, 8'h20, 8'h00);
    check("rst_discards_write", bus.out, 8'h00);
    op(1, 0, 8'h42, 8'h00);
    check("rst_cleared_42", bus.out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
